// File: rtl/iis_transmit.sv
// IIS transmitter: fetches 16-bit samples from a sync FIFO and serialises them MSB-first
// into alternating left/right 32-slot half-frames. Optional build macro: IIS_TX_REPEAT_ON_UNDERRUN_EN.
module iis_transmit #(
   parameter int unsigned data_depth = 1024
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        tx_en,
   input  logic        fifo_empty,
   input  logic [15:0] fifo_rdata,
   output logic        fifo_rden,
   output logic        WS,
   output logic        DATA,
   output logic [31:0] tx_num,
   output logic        tx_finish,
   output logic        underrun
);

   typedef enum logic [1:0] {IDLE, PREFETCH, LATCH, RUN} state_t;

   localparam int unsigned SAMPLE_W = 16;

   state_t              state;
   logic [4:0]          slot;
   logic [SAMPLE_W-1:0] hold;
   logic [SAMPLE_W-1:0] shift;
   logic                fetched;
   logic [SAMPLE_W-1:0] uval_c;
   logic [SAMPLE_W-1:0] sample_c;
   logic [4:0]          slot_nxt_c;
   logic                at_depth_c;
   logic [31:0]         depth_c;

   assign depth_c    = 32'(data_depth);
   assign at_depth_c = (tx_num == depth_c);
   assign slot_nxt_c = slot + 5'd1;

`ifdef IIS_TX_REPEAT_ON_UNDERRUN_EN
   logic [SAMPLE_W-1:0] prev_l;
   logic [SAMPLE_W-1:0] prev_r;
   // The fetch always targets the channel opposite the current WS (left after IDLE).
   assign uval_c = WS ? prev_r : prev_l;

   always_ff @(posedge clk) begin
      if (rst) begin
         prev_l <= '0;
         prev_r <= '0;
      end else if (tx_en) begin
         if (state == LATCH)
            prev_l <= sample_c;
         else if (state == RUN && slot_nxt_c == 5'd0 && !at_depth_c) begin
            if (!WS) prev_l <= hold;
            else     prev_r <= hold;
         end
      end
   end
`else
   assign uval_c = '0;
`endif

   assign sample_c = fetched ? fifo_rdata : uval_c;

   always_ff @(posedge clk) begin
      if (rst || !tx_en) begin
         state     <= IDLE;
         slot      <= '0;
         hold      <= '0;
         shift     <= '0;
         fetched   <= 1'b0;
         fifo_rden <= 1'b0;
         WS        <= 1'b0;
         DATA      <= 1'b0;
         tx_num    <= '0;
         tx_finish <= 1'b0;
         underrun  <= 1'b0;
      end else begin
         fifo_rden <= 1'b0;
         fetched   <= fifo_rden;
         case (state)
            IDLE: begin
               WS   <= 1'b0;
               DATA <= 1'b0;
               if (!tx_finish) begin
                  state     <= PREFETCH;
                  fifo_rden <= !fifo_empty;
                  if (fifo_empty) underrun <= 1'b1;
               end
            end
            PREFETCH: state <= LATCH;
            LATCH: begin
               hold  <= sample_c;
               shift <= sample_c;
               WS    <= 1'b1;
               DATA  <= 1'b0;
               slot  <= '0;
               state <= RUN;
            end
            RUN: begin
               slot <= slot_nxt_c;
               if (slot_nxt_c == 5'd0) begin
                  DATA <= 1'b0;
                  if (at_depth_c) begin
                     state <= IDLE;
                     WS    <= 1'b0;
                  end else begin
                     WS    <= !WS;
                     shift <= hold;
                  end
               end else if (slot_nxt_c <= 5'd16) begin
                  DATA  <= shift[SAMPLE_W-1];
                  shift <= {shift[SAMPLE_W-2:0], 1'b0};
               end else begin
                  DATA <= 1'b0;
               end
               if (slot_nxt_c == 5'd16) begin
                  tx_num    <= tx_num + 32'd1;
                  tx_finish <= ((tx_num + 32'd1) == depth_c);
               end
               // Prefetch for the next half-frame; suppressed once the run is complete.
               if (slot_nxt_c == 5'd29 && !at_depth_c) begin
                  fifo_rden <= !fifo_empty;
                  if (fifo_empty) underrun <= 1'b1;
               end
               if (slot == 5'd30) hold <= sample_c;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_iis_transmit.sv
// Directed bench for iis_transmit (data_depth=2) with a registered-read FIFO model
// and per-cycle output traces checked against hand-computed vectors.
module tb_iis_transmit;

   logic        clk = 1'b0;
   logic        rst;
   logic        tx_en;
   logic        fifo_empty;
   logic [15:0] fifo_rdata;
   logic        fifo_rden;
   logic        WS;
   logic        DATA;
   logic [31:0] tx_num;
   logic        tx_finish;
   logic        underrun;

   int n_chk  = 0;
   int n_fail = 0;

   iis_transmit #(.data_depth(2)) dut (
      .clk(clk), .rst(rst), .tx_en(tx_en), .fifo_empty(fifo_empty),
      .fifo_rdata(fifo_rdata), .fifo_rden(fifo_rden), .WS(WS), .DATA(DATA),
      .tx_num(tx_num), .tx_finish(tx_finish), .underrun(underrun)
   );

   always #5 clk = ~clk;

   // FIFO model: data valid the cycle after the read strobe
   logic [15:0] mem [0:63];
   int wr_cnt = 0;
   int rd_ptr = 0;
   assign fifo_empty = (rd_ptr == wr_cnt);

   initial fifo_rdata = 16'h0;
   always @(posedge clk) begin
      if (fifo_rden && rd_ptr != wr_cnt) begin
         fifo_rdata <= mem[rd_ptr % 64];
         rd_ptr     <= rd_ptr + 1;
      end
   end

   task automatic push(input logic [15:0] v);
      mem[wr_cnt % 64] = v;
      wr_cnt++;
   endtask

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   logic        tr_ws   [0:127];
   logic        tr_data [0:127];
   logic        tr_rden [0:127];
   logic [31:0] tr_txn  [0:127];
   logic        tr_fin  [0:127];
   logic        tr_und  [0:127];

   task automatic record(input int n);
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         tr_ws[i]   = WS;
         tr_data[i] = DATA;
         tr_rden[i] = fifo_rden;
         tr_txn[i]  = tx_num;
         tr_fin[i]  = tx_finish;
         tr_und[i]  = underrun;
      end
   endtask

   function automatic logic [15:0] word_at(input int k0);
      logic [15:0] w;
      w = '0;
      for (int s = 1; s <= 16; s++) w = {w[14:0], tr_data[k0 + s]};
      return w;
   endfunction

   function automatic int rden_count(input int n);
      int c;
      c = 0;
      for (int i = 0; i < n; i++) if (tr_rden[i]) c++;
      return c;
   endfunction

   typedef struct {
      string       nm;
      int          k;
      logic        ws;
      logic        data;
      logic        rden;
      logic [31:0] txn;
      logic        fin;
      logic        und;
   } vec_t;

   vec_t tv [15];

   initial begin
      // Trace index k is sampled between edges E+k and E+k+1; left slot s = k-2, right slot s = k-34
      tv[0]  = '{"prefetch",   0, 1'b0, 1'b0, 1'b1, 0, 1'b0, 1'b0};
      tv[1]  = '{"latch",      1, 1'b0, 1'b0, 1'b0, 0, 1'b0, 1'b0};
      tv[2]  = '{"l_slot0",    2, 1'b1, 1'b0, 1'b0, 0, 1'b0, 1'b0};
      tv[3]  = '{"l_msb",      3, 1'b1, 1'b1, 1'b0, 0, 1'b0, 1'b0};
      tv[4]  = '{"l_slot15",  17, 1'b1, 1'b1, 1'b0, 0, 1'b0, 1'b0};
      tv[5]  = '{"l_slot16",  18, 1'b1, 1'b1, 1'b0, 1, 1'b0, 1'b0};
      tv[6]  = '{"l_slot17",  19, 1'b1, 1'b0, 1'b0, 1, 1'b0, 1'b0};
      tv[7]  = '{"l_slot29",  31, 1'b1, 1'b0, 1'b1, 1, 1'b0, 1'b0};
      tv[8]  = '{"l_slot31",  33, 1'b1, 1'b0, 1'b0, 1, 1'b0, 1'b0};
      tv[9]  = '{"r_slot0",   34, 1'b0, 1'b0, 1'b0, 1, 1'b0, 1'b0};
      tv[10] = '{"r_msb",     35, 1'b0, 1'b0, 1'b0, 1, 1'b0, 1'b0};
      tv[11] = '{"r_slot16",  50, 1'b0, 1'b0, 1'b0, 2, 1'b1, 1'b0};
      tv[12] = '{"r_slot29",  63, 1'b0, 1'b0, 1'b0, 2, 1'b1, 1'b0};
      tv[13] = '{"idle",      66, 1'b0, 1'b0, 1'b0, 2, 1'b1, 1'b0};
      tv[14] = '{"idle_late", 69, 1'b0, 1'b0, 1'b0, 2, 1'b1, 1'b0};

      rst   = 1'b1;
      tx_en = 1'b1;
      push(16'hA5C3);
      push(16'h1234);
      repeat (3) @(negedge clk);
      check("rst_ws",   WS,        0);
      check("rst_data", DATA,      0);
      check("rst_rden", fifo_rden, 0);
      check("rst_txn",  tx_num,    0);
      check("rst_fin",  tx_finish, 0);
      check("rst_und",  underrun,  0);

      // Normal two-sample run straight out of reset
      rst = 1'b0;
      record(70);
      for (int i = 0; i < 15; i++) begin
         check({tv[i].nm, "_ws"},   tr_ws[tv[i].k],   tv[i].ws);
         check({tv[i].nm, "_data"}, tr_data[tv[i].k], tv[i].data);
         check({tv[i].nm, "_rden"}, tr_rden[tv[i].k], tv[i].rden);
         check({tv[i].nm, "_txn"},  tr_txn[tv[i].k],  tv[i].txn);
         check({tv[i].nm, "_fin"},  tr_fin[tv[i].k],  tv[i].fin);
         check({tv[i].nm, "_und"},  tr_und[tv[i].k],  tv[i].und);
      end
      check("left_word",  word_at(2),  16'hA5C3);
      check("right_word", word_at(34), 16'h1234);
      check("rden_pulses", rden_count(70), 2);

      // Drop enable: finish and count clear
      tx_en = 1'b0;
      @(negedge clk);
      check("clr_txn", tx_num,    0);
      check("clr_fin", tx_finish, 0);

      // Underrun on the slot-29 read for the right half-frame
      push(16'hBEEF);
      tx_en = 1'b1;
      record(70);
      check("ur_left_word",  word_at(2),  16'hBEEF);
      check("ur_und_before", tr_und[30],  0);
      check("ur_und_set",    tr_und[31],  1);
      check("ur_no_rden",    tr_rden[31], 0);
      check("ur_right_word", word_at(34), 16'h0000);
      check("ur_right_ws",   tr_ws[40],   0);
      check("ur_txn",        tr_txn[66],  2);
      check("ur_fin",        tr_fin[66],  1);
      check("ur_sticky",     tr_und[69],  1);

      tx_en = 1'b0;
      @(negedge clk);
      check("clr2_und", underrun, 0);

      // Abort at right slot 10 (after an underrun) then restart
      push(16'h8001);
      tx_en = 1'b1;
      record(45);
      check("ab_left_word", word_at(2),  16'h8001);
      check("ab_pre_ws",    tr_ws[44],   0);
      check("ab_pre_txn",   tr_txn[44],  1);
      check("ab_pre_und",   tr_und[44],  1);
      tx_en = 1'b0;
      @(negedge clk);
      check("ab_ws",   WS,        0);
      check("ab_data", DATA,      0);
      check("ab_rden", fifo_rden, 0);
      check("ab_txn",  tx_num,    0);
      check("ab_und",  underrun,  0);
      check("ab_fin",  tx_finish, 0);

      push(16'h7FFE);
      tx_en = 1'b1;
      record(40);
      check("rs_latch_ws", tr_ws[1],   0);
      check("rs_left_ws",  tr_ws[2],   1);
      check("rs_word",     word_at(2), 16'h7FFE);
      check("rs_txn",      tr_txn[18], 1);
      check("rs_right_ws", tr_ws[34],  0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
